// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider owning HI/LO.
// Define MULDIV_SIGNED_EN to build signed MULT/DIV with sign fix-up.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] s1val,
  input  logic [WIDTH-1:0] s2val,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t state_q, state_d;

  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_n;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   a_raw_q;
  logic               is_div_q;
  logic               dz_q;
  logic               neg_q_q, neg_r_q;

  logic               go, mt;
  logic               neg_a, neg_b;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     shifted;
  logic               ge;
  logic [WIDTH-1:0]   diff, rem_n;
  logic [WIDTH-1:0]   fin_hi, fin_lo;

  assign go = (state_q == IDLE) && start && !flush && !op[2];
  assign mt = (state_q == IDLE) && start && !flush && (op[2:1] == 2'b10);

`ifdef MULDIV_SIGNED_EN
  assign neg_a = op[0] & s1val[WIDTH-1];
  assign neg_b = op[0] & s2val[WIDTH-1];
`else
  assign neg_a = 1'b0;
  assign neg_b = 1'b0;
`endif

  assign a_mag = neg_a ? -s1val : s1val;
  assign b_mag = neg_b ? -s2val : s2val;

  // Multiplier lives in the low half and shifts out as the product shifts in.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, opnd_q} : '0);

  assign shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign ge      = shifted >= {1'b0, opnd_q};
  assign diff    = shifted[WIDTH-1:0] - opnd_q;
  assign rem_n   = ge ? diff : shifted[WIDTH-1:0];

  always_comb begin
    acc_n = acc_q;
    if (is_div_q) begin
      if (!dz_q)
        acc_n = {rem_n, acc_q[WIDTH-2:0], ge};
    end else begin
      acc_n = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    fin_hi = acc_q[2*WIDTH-1:WIDTH];
    fin_lo = acc_q[WIDTH-1:0];
    if (is_div_q) begin
      if (dz_q) begin
        fin_hi = a_raw_q;
        fin_lo = '1;
      end else begin
        if (neg_r_q) fin_hi = -acc_q[2*WIDTH-1:WIDTH];
        if (neg_q_q) fin_lo = -acc_q[WIDTH-1:0];
      end
    end else if (neg_q_q) begin
      {fin_hi, fin_lo} = -acc_q;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (go) state_d = RUN;
      RUN:     if (cnt_q == CW'(1)) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      opnd_q      <= '0;
      a_raw_q     <= '0;
      is_div_q    <= 1'b0;
      dz_q        <= 1'b0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      if (go) begin
        cnt_q    <= CW'(WIDTH);
        acc_q    <= {{WIDTH{1'b0}}, a_mag};
        opnd_q   <= b_mag;
        a_raw_q  <= s1val;
        is_div_q <= op[1];
        dz_q     <= op[1] && (s2val == '0);
        neg_q_q  <= neg_a ^ neg_b;
        neg_r_q  <= neg_a;
      end
      if (mt && !op[0]) hi <= s1val;
      if (mt &&  op[0]) lo <= s1val;
      if (state_q == RUN) begin
        cnt_q <= cnt_q - CW'(1);
        acc_q <= acc_n;
      end
      if (state_q == FIN && !flush) begin
        hi          <= fin_hi;
        lo          <= fin_lo;
        done        <= 1'b1;
        div_by_zero <= is_div_q & dz_q;
      end
    end
  end

  assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit (WIDTH = 32).
// Expected results follow MULDIV_SIGNED_EN when it is defined.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  op;
  logic [31:0] s1val, s2val;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_run = 0;
  int n_fail = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .s1val(s1val), .s2val(s2val), .flush(flush),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o,
                       input logic [31:0] a,
                       input logic [31:0] b);
    start = 1'b1; op = o; s1val = a; s2val = b;
    tick();
    start = 1'b0;
  endtask

  // Waits for done; counts cycles and cycles where busy was low.
  task automatic wait_done(input int poke_at,
                           output int n,
                           output int nb);
    n = 0;
    nb = 0;
    while (!done && n < 100) begin
      if (!busy) nb++;
      if (n == poke_at) begin
        start = 1'b1; op = 3'b000; s1val = 2; s2val = 2;
      end
      tick();
      start = 1'b0;
      n++;
    end
  endtask

  // Counts done pulses seen over a fixed window.
  task automatic count_done(input int cycles, output int nd);
    nd = 0;
    for (int i = 0; i < cycles; i++) begin
      if (done) nd++;
      tick();
    end
  endtask

  int lat, nb, nd;

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0;
    op = '0; s1val = '0; s2val = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_busy", busy, 1);
    wait_done(-1, lat, nb);
    check("multu_lat", lat, 33);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);
    check("multu_dbz", div_by_zero, 0);
    tick();
    check("multu_pulse", done, 0);

    issue(3'b010, 100, 7);
    wait_done(5, lat, nb);
    check("divu_lat", lat, 33);
    check("divu_busy_gap", nb, 0);
    check("divu_lo", lo, 14);
    check("divu_hi", hi, 2);
    check("divu_dbz", div_by_zero, 0);
    tick();
    check("divu_noqueue", busy, 0);
    count_done(40, nd);
    check("divu_noqueue_done", nd, 0);

    issue(3'b010, 5, 0);
    wait_done(-1, lat, nb);
    check("dz_lat", lat, 33);
    check("dz_lo", lo, 32'hFFFF_FFFF);
    check("dz_hi", hi, 5);
    check("dz_flag", div_by_zero, 1);
    tick();
    check("dz_pulse", div_by_zero, 0);

    issue(3'b100, 32'h1234, 0);
    check("mthi_hi", hi, 32'h1234);
    check("mthi_busy", busy, 0);
    issue(3'b101, 32'hABCD, 0);
    check("mtlo_lo", lo, 32'hABCD);
    check("mtlo_hi", hi, 32'h1234);
    check("mtlo_busy", busy, 0);
    check("mtlo_done", done, 0);

    issue(3'b000, 3, 4);
    for (int i = 0; i < 9; i++) tick();
    check("flush_pre_busy", busy, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", busy, 0);
    count_done(40, nd);
    check("flush_done", nd, 0);
    check("flush_hilo", {hi, lo}, {32'h1234, 32'hABCD});

    flush = 1'b1;
    issue(3'b000, 3, 4);
    flush = 1'b0;
    check("flush_start_busy", busy, 0);

    issue(3'b110, 9, 9);
    check("rsvd_busy", busy, 0);
    check("rsvd_hilo", {hi, lo}, {32'h1234, 32'hABCD});

    issue(3'b010, 100, 7);
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid", {31'd0, busy, hi, lo}, 0);
    count_done(40, nd);
    check("rstmid_done", nd, 0);

    issue(3'b011, 32'hFFFF_FFF9, 2);
    wait_done(-1, lat, nb);
`ifdef MULDIV_SIGNED_EN
    check("div_s", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
`else
    check("div_s", {hi, lo}, {32'h0000_0001, 32'h7FFF_FFFC});
`endif

    issue(3'b001, 32'hFFFF_FFFD, 5);
    wait_done(-1, lat, nb);
`ifdef MULDIV_SIGNED_EN
    check("mult_s", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
`else
    check("mult_s", {hi, lo}, 64'h0000_0004_FFFF_FFF1);
`endif

    issue(3'b011, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(-1, lat, nb);
`ifdef MULDIV_SIGNED_EN
    check("div_minneg", {hi, lo}, {32'h0, 32'h8000_0000});
`else
    check("div_minneg", {hi, lo}, {32'h8000_0000, 32'h0});
`endif

    issue(3'b010, 32'h8000_0000, 32'h0000_0003);
    wait_done(-1, lat, nb);
    check("divu_big", {hi, lo}, {32'h2, 32'h2AAA_AAAA});

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
